dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-master arbiter sharing the single data-memory port (byte write mask, word address, 1-cycle synchronous read) between the CPU data port (m0) and a debug/loader master (m1), e.g. a UART program loader.
- Sits between the CPU/loader and the dmem instance in the top level.
- Round-robin grant, valid/ready request handshake, registered read-response routing.
- Out-of-range accesses are rejected with an error flag.

Parameters:
- ADDR_W, 32, byte-address width of master ports.
- DEPTH, 1024, memory depth in 32-bit words; legal byte addresses are 0 .. 4*DEPTH-1.
- MAX_HOLD, 8, max consecutive grants to one master while the other is requesting (1..255).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- m0_valid  in  1  CPU request valid
- m0_wmask  in  4  byte write mask; 0 = read
- m0_addr  in  ADDR_W  byte address
- m0_wdata  in  32  write data
- m0_ready  out  1  request accepted this cycle
- m0_rvalid  out  1  read data/error valid
- m0_rdata  out  32  read data
- m0_err  out  1  address out of range (with rvalid, or with ready on writes)
- m1_valid, m1_wmask, m1_addr, m1_wdata, m1_ready, m1_rvalid, m1_rdata, m1_err: same for loader
- mem_en  out  1  memory access strobe
- mem_wmask  out  4  memory byte write mask
- mem_addr  out  $clog2(DEPTH)  word address (byte addr >> 2)
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid one cycle after mem_en with mem_wmask==0

Behaviour:
- Reset (async, resetn=0):
  - m*_rvalid, m*_err registers, response-owner register cleared.
  - RR pointer = m0 preferred; hold counter = 0.
  - With resetn low, m*_ready and mem_en forced 0.
- Handshake: master holds valid/wmask/addr/wdata stable until ready=1. Transfer occurs in the cycle valid&ready.
- Arbitration (combinational on registered state):
  - Only one requester -> it wins.
  - Both requesting -> RR pointer's master wins, unless that master has held MAX_HOLD consecutive grants, then the other wins.
  - Pointer updates to the non-winner after every grant.
  - Hold counter increments on a repeat grant to the same master, resets to 1 on a switch, resets to 0 on an idle cycle.
- Issue: winner's request is driven onto mem_* with mem_en=1, but only when addr is in range.
  - Out of range -> mem_en=0, ready still 1, write dropped.
- Read latency: read accepted in cycle T -> owner's rvalid=1 in T+1.
  - rdata = mem_rdata, or 0 with err=1 if out of range.
  - Non-owner rvalid stays 0.
- Writes: no rvalid. Out-of-range write asserts err combinationally with ready in T.
- Throughput: one access per cycle; back-to-back reads alternate masters with responses correctly routed via the owner register.
- States (response register): IDLE, RESP_M0, RESP_M1.
  - Next state = owner of a read accepted this cycle, else IDLE.
- mem_addr/mem_wdata/mem_wmask are 0 when mem_en=0.
- Misaligned addr: addr[1:0] ignored.
- Reset mid-operation: pending read response discarded; no rvalid after reset release until a new read is accepted.

Decomposition:
- Package dmem_arb_pkg:
  - owner_t enum {OWN_NONE, OWN_M0, OWN_M1}
  - NUM_MASTERS=2
  - range-check function
- One sub-module, rr_arbiter2: pointer, hold counter and grant logic. The top handles muxing, range check and response routing.

Test Plan:
- Reset: assert resetn=0 mid read -> all rvalid/ready/mem_en 0. After release, first m0 read of addr 0x10 -> mem_addr=4, m0_rvalid next cycle with mem_rdata.
- Solo master: m0 write wmask=4'b0011 addr 0x20 wdata 0xDEADBEEF, then read 0x20.
  - mem_en/mem_wmask=0011/mem_addr=8 in write cycle.
  - Read rvalid one cycle after acceptance, rdata=0x0000BEEF (memory preloaded 0).
- Contention: both valid continuously with reads -> grants alternate m0,m1,m0,...; each rvalid only on owner's port, one cycle after its grant.
- MAX_HOLD=2, m1 request raised while m0 repeatedly granted -> m0 gets ≤2 consecutive grants, then m1 granted.
- Out of range: m1 read addr 4*DEPTH -> m1_ready=1, mem_en=0, next cycle m1_rvalid=1, m1_err=1, rdata=0. Out-of-range write -> err with ready, memory unchanged.
- Stability: m0_valid held low while m0_ready was 0 for 3 cycles -> no transfer. Verify with assertions that req fields are sampled only on valid&ready.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-master data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

   localparam int unsigned NUM_MASTERS = 2;

   // Byte address is legal when it falls inside the DEPTH-word memory.
   function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned depth);
      return addr < (64'(depth) << 2);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a cap on consecutive grants to one master.
module rr_arbiter2
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NUM_MASTERS-1:0] req,
   output logic [NUM_MASTERS-1:0] gnt
);

   logic       ptr_q;
   logic       last_q;
   logic [7:0] hold_q;
   logic       win;

   always_comb begin
      win = req[1];
      if (req == 2'b11) begin
         win = ptr_q;
         if ((last_q == ptr_q) && (hold_q >= 8'(MAX_HOLD)))
            win = ~ptr_q;
      end
      gnt = '0;
      if (resetn && (req != '0))
         gnt = win ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ptr_q  <= 1'b0;
         last_q <= 1'b0;
         hold_q <= '0;
      end else if (gnt != '0) begin
         ptr_q  <= ~win;
         last_q <= win;
         // Counting up from 0 after an idle cycle naturally yields 1.
         if (win == last_q)
            hold_q <= (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
         else
            hold_q <= 8'd1;
      end else begin
         hold_q <= '0;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU (m0) and a debug/loader master (m1),
// with range checking and registered routing of read responses.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned MAX_HOLD = 8,
   localparam int unsigned MEM_AW  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              m0_valid,
   input  logic [3:0]        m0_wmask,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   output logic              m0_ready,
   output logic              m0_rvalid,
   output logic [31:0]       m0_rdata,
   output logic              m0_err,
   input  logic              m1_valid,
   input  logic [3:0]        m1_wmask,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   output logic              m1_ready,
   output logic              m1_rvalid,
   output logic [31:0]       m1_rdata,
   output logic              m1_err,
   output logic              mem_en,
   output logic [3:0]        mem_wmask,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   logic [NUM_MASTERS-1:0] gnt;
   logic                   sel;
   logic                   any_gnt;
   logic [3:0]             r_wmask;
   logic [ADDR_W-1:0]      r_addr;
   logic [31:0]            r_wdata;
   logic                   r_ok;
   logic                   rd_acc;
   logic                   wr_err;
   owner_t                 owner_q;
   logic [1:0]             rvalid_q;
   logic [1:0]             rerr_q;

   rr_arbiter2 #(.MAX_HOLD(MAX_HOLD)) u_arb (
      .clk    (clk),
      .resetn (resetn),
      .req    ({m1_valid, m0_valid}),
      .gnt    (gnt)
   );

   always_comb begin
      sel       = gnt[1];
      any_gnt   = |gnt;
      r_wmask   = sel ? m1_wmask : m0_wmask;
      r_addr    = sel ? m1_addr  : m0_addr;
      r_wdata   = sel ? m1_wdata : m0_wdata;
      r_ok      = addr_in_range(64'(r_addr), DEPTH);
      mem_en    = any_gnt & r_ok;
      mem_wmask = mem_en ? r_wmask : '0;
      mem_addr  = mem_en ? r_addr[MEM_AW+1:2] : '0;
      mem_wdata = mem_en ? r_wdata : '0;
      rd_acc    = any_gnt && (r_wmask == 4'b0000);
      wr_err    = any_gnt && (r_wmask != 4'b0000) && !r_ok;
   end

   assign m0_ready  = gnt[0];
   assign m1_ready  = gnt[1];
   assign m0_rvalid = rvalid_q[0];
   assign m1_rvalid = rvalid_q[1];
   // Read errors arrive with rvalid; write errors are flagged with ready.
   assign m0_err    = rerr_q[0] | (wr_err & ~sel);
   assign m1_err    = rerr_q[1] | (wr_err & sel);
   assign m0_rdata  = ((owner_q == OWN_M0) && !rerr_q[0]) ? mem_rdata : '0;
   assign m1_rdata  = ((owner_q == OWN_M1) && !rerr_q[1]) ? mem_rdata : '0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner_q  <= OWN_NONE;
         rvalid_q <= '0;
         rerr_q   <= '0;
      end else begin
         owner_q  <= OWN_NONE;
         rvalid_q <= '0;
         rerr_q   <= '0;
         if (rd_acc) begin
            owner_q  <= sel ? OWN_M1 : OWN_M0;
            rvalid_q <= sel ? 2'b10 : 2'b01;
            rerr_q   <= r_ok ? 2'b00 : (sel ? 2'b10 : 2'b01);
         end
      end
   end

endmodule
